// File: rtl/mmss_pkg.sv
// rtl/mmss_pkg.sv - shared state encoding and default field limits for the mm:ss counter
package mmss_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PAUSED = 2'd1,
    ST_ADJUST = 2'd2
  } state_t;

  localparam int MMSS_W       = 6;
  localparam int MMSS_SEC_MAX = 59;
  localparam int MMSS_MIN_MAX = 59;

endpackage

// File: rtl/wrap_counter.sv
// rtl/wrap_counter.sv - modulo MAX+1 up/down field counter with terminal-count carry
module wrap_counter #(
  parameter int W   = 6,
  parameter int MAX = 59
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         dir,
  output logic [W-1:0] value,
  output logic         carry
);

  localparam logic [W-1:0] TOP = W'(MAX);
  localparam logic [W-1:0] ONE = W'(1);

  generate
    if (MAX <= 0 || MAX >= (1 << W)) begin : g_bad_max
      $error("wrap_counter: MAX must be in 1..2**W-1");
    end
  endgenerate

  logic at_end;

  // Terminal value depends on direction: MAX going up, 0 going down.
  assign at_end = dir ? (value == '0) : (value == TOP);
  assign carry  = en & at_end;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value <= '0;
    end else if (en) begin
      if (at_end)   value <= dir ? TOP : '0;
      else if (dir) value <= value - ONE;
      else          value <= value + ONE;
    end
  end

endmodule

// File: rtl/mmss_counter.sv
// rtl/mmss_counter.sv - minutes:seconds stopwatch with run/pause/adjust FSM and lap capture
module mmss_counter
  import mmss_pkg::*;
#(
  parameter int W       = MMSS_W,
  parameter int SEC_MAX = MMSS_SEC_MAX,
  parameter int MIN_MAX = MMSS_MIN_MAX
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tick,
  input  logic         adj_tick,
  input  logic         pause,
  input  logic         adj,
  input  logic         sel,
  input  logic         dir,
  input  logic         lap,
  output logic [W-1:0] minutes,
  output logic [W-1:0] seconds,
  output logic [W-1:0] lap_minutes,
  output logic [W-1:0] lap_seconds,
  output logic         lap_valid,
  output logic         wrap,
  output logic [1:0]   state
);

  state_t state_q;
  logic   resume;
  logic   in_run, in_adjust;
  logic   sec_en, min_en, sec_carry, min_carry;

  assign in_run    = (state_q == ST_RUN);
  assign in_adjust = (state_q == ST_ADJUST);

  // In RUN minutes follow the seconds carry; in ADJUST each field steps alone.
  assign sec_en = (in_run & tick) | (in_adjust & adj_tick & sel);
  assign min_en = (in_run & tick & sec_carry) | (in_adjust & adj_tick & ~sel);

  wrap_counter #(.W(W), .MAX(SEC_MAX)) u_sec (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (sec_en),
    .dir   (dir),
    .value (seconds),
    .carry (sec_carry)
  );

  wrap_counter #(.W(W), .MAX(MIN_MAX)) u_min (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (min_en),
    .dir   (dir),
    .value (minutes),
    .carry (min_carry)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      resume      <= 1'b0;
      wrap        <= 1'b0;
      lap_minutes <= '0;
      lap_seconds <= '0;
      lap_valid   <= 1'b0;
    end else begin
      wrap <= in_run & tick & sec_carry & min_carry;

      if (lap) begin
        lap_minutes <= minutes;
        lap_seconds <= seconds;
        lap_valid   <= 1'b1;
      end

      // adj has priority; resume is only captured on entry so re-asserting adj keeps it.
      if (adj) begin
        state_q <= ST_ADJUST;
        if (!in_adjust) resume <= (state_q == ST_PAUSED);
      end else begin
        case (state_q)
          ST_RUN:    state_q <= pause ? ST_PAUSED : ST_RUN;
          ST_PAUSED: state_q <= pause ? ST_RUN : ST_PAUSED;
          ST_ADJUST: state_q <= resume ? ST_PAUSED : ST_RUN;
          default:   state_q <= ST_RUN;
        endcase
      end
    end
  end

  assign state = state_q;

endmodule

// File: doc/mmss_counter.md
MMSS_COUNTER -- requirements
Module: mmss_counter

Interface
REQ-001 Parameter W, default 6: width of every minutes/seconds field.
REQ-002 Parameter SEC_MAX, default 59: terminal value of the seconds field.
REQ-003 Parameter MIN_MAX, default 59: terminal value of the minutes field.
REQ-004 clk  input  1  single system clock; all state SHALL change only on posedge clk.
REQ-005 rst_n  input  1  reset is synchronous and active-low.
REQ-006 tick  input  1  one-cycle count enable (1 Hz strobe).
REQ-007 adj_tick  input  1  one-cycle adjust enable (2 Hz strobe).
REQ-008 pause  input  1  one-cycle pulse that toggles run/pause.
REQ-009 adj  input  1  level; 1 = adjust mode.
REQ-010 sel  input  1  level; in adjust mode, 1 = seconds and 0 = minutes.
REQ-011 dir  input  1  level; 0 = count up, 1 = count down.
REQ-012 lap  input  1  one-cycle pulse that captures the split time.
REQ-013 minutes, seconds  output  W each  current time, registered.
REQ-014 lap_minutes, lap_seconds  output  W each  captured split time.
REQ-015 lap_valid  output  1  high once any lap has been captured.
REQ-016 wrap  output  1  one-cycle pulse on full-time rollover in either direction.
REQ-017 state  output  2  current FSM state encoding.

Function
REQ-018 FSM states SHALL be RUN=0, PAUSED=1, ADJUST=2; encoding 3 is unused and SHALL return to RUN.
REQ-019 Any state with adj=1 SHALL go to ADJUST next cycle, saving resume = (state==PAUSED).
REQ-020 ADJUST with adj=0 SHALL go to PAUSED if resume=1, else RUN.
REQ-021 pause=1 with adj=0 SHALL toggle RUN<->PAUSED; pause SHALL be ignored in ADJUST and in the cycle adj rises.
REQ-022 RUN with tick=1 and dir=0 SHALL increment seconds; at SEC_MAX, seconds goes to 0 and minutes increments.
REQ-023 At MIN_MAX:SEC_MAX counting up, the time SHALL go to 0:0 and wrap SHALL pulse 1 cycle.
REQ-024 RUN with tick=1 and dir=1 SHALL decrement seconds; at 0, seconds goes to SEC_MAX and minutes decrements.
REQ-025 At 0:0 counting down, the time SHALL go to MIN_MAX:SEC_MAX and wrap SHALL pulse.
REQ-026 ADJUST with adj_tick=1 SHALL step only the field chosen by sel, wrapping within 0..MAX per dir; the other field SHALL hold; wrap SHALL stay 0.
REQ-027 PAUSED SHALL hold time; tick and adj_tick SHALL be ignored.
REQ-028 tick SHALL be ignored in ADJUST; adj_tick SHALL be ignored in RUN.
REQ-029 Counter update latency SHALL be 1 cycle: the new value is visible the cycle after the enable.
REQ-030 lap=1 in any state SHALL load lap_* with minutes/seconds as they stood before that cycle's update, and set lap_valid.
REQ-031 lap_valid SHALL clear only on reset.
REQ-032 A dir change SHALL take effect on the next enabled step with no glitch step.
REQ-033 All arithmetic SHALL be W-bit modulo the field MAX+1; values above MAX SHALL never appear.
REQ-034 Elaboration SHALL fail if SEC_MAX or MIN_MAX >= 2**W, or if either is 0.

Reset
REQ-035 rst_n=0 at posedge clk SHALL force minutes=0, seconds=0, lap_*=0, lap_valid=0, wrap=0, state=RUN, resume=0.
REQ-036 Reset SHALL override all inputs in the same cycle, including mid-adjust and mid-pause.

Structure
REQ-037 Package mmss_pkg SHALL hold the state enum and the default W, SEC_MAX and MIN_MAX constants.
REQ-038 Sub-module wrap_counter (params W, MAX; inputs en, dir; outputs value, carry) SHALL be instantiated once each for seconds and minutes.

Verification
REQ-039 Reset, then 60 ticks in RUN with dir=0 -> 01:00 and no wrap pulse.
REQ-040 Preload 59:59, one tick with dir=0 -> 00:00 with wrap=1 for exactly 1 cycle.
REQ-041 From 00:00, one tick with dir=1 -> 59:59 with wrap=1.
REQ-042 At 05:10 in RUN: pause pulse, then 3 ticks -> remains 05:10 in PAUSED; adj=1, sel=0, then 2 adj_ticks -> 07:10; adj=0 -> PAUSED.
REQ-043 At 02:30, lap and tick in the same cycle -> lap=02:30, lap_valid=1, time=02:31.
REQ-044 rst_n=0 asserted while in ADJUST at 07:10 -> all outputs 0 and state=RUN on the next cycle.
